// File: rtl/approx_mult_bist_pkg.sv
// Shared types and width helpers for the approximate-multiplier BIST engine.
// Optional error statistics are enabled by defining BIST_ERR_STATS_EN.
package approx_mult_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Settle counter covers SETTLE up to 15
    localparam int unsigned SETTLE_W = 4;

    function automatic int unsigned prod_w(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned count_w(input int unsigned n);
        return 2 * n + 1;
    endfunction

    function automatic int unsigned sum_w(input int unsigned n);
        return 4 * n;
    endfunction

endpackage

// File: rtl/bist_err_calc.sv
// Combinational compare of a DUT product against the exact product.
// The distance output exists only when BIST_ERR_STATS_EN is defined.
module bist_err_calc
    import approx_mult_bist_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [2*N-1:0] y,
    output logic           match
`ifdef BIST_ERR_STATS_EN
    ,
    output logic [2*N-1:0] dist
`endif
);

    localparam int unsigned PW = prod_w(N);

    logic [PW-1:0] exact;

    assign exact = PW'(a) * PW'(b);
    assign match = (y == exact);

`ifdef BIST_ERR_STATS_EN
    assign dist = (y >= exact) ? (y - exact) : (exact - y);
`endif

endmodule

// File: rtl/approx_mult_bist.sv
// Sweeps every operand pair into a multiplier under test and counts exact matches.
// Defining BIST_ERR_STATS_EN adds error-distance sum and maximum outputs.
module approx_mult_bist
    import approx_mult_bist_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [N-1:0]     dut_a,
    output logic [N-1:0]     dut_b,
    input  logic [2*N-1:0]   dut_y,
    output logic             busy,
    output logic             done,
    output logic [2*N:0]     correct_count
`ifdef BIST_ERR_STATS_EN
    ,
    output logic [4*N-1:0]   err_sum,
    output logic [2*N-1:0]   err_max
`endif
);

    localparam int unsigned PW = prod_w(N);
    localparam int unsigned CW = count_w(N);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam state_t FIRST_ST = (SETTLE == 0) ? ST_CHECK : ST_WAIT;

    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]        a_d, b_d;
    logic                busy_d, done_d;
    logic [CW-1:0]       count_d;
    logic                match;
    logic                last_vec;

    assign last_vec = (dut_a == {N{1'b1}}) && (dut_b == {N{1'b1}});

`ifdef BIST_ERR_STATS_EN
    localparam int unsigned SW = sum_w(N);
    logic [PW-1:0] dist;
    logic [SW-1:0] sum_d;
    logic [PW-1:0] max_d;

    bist_err_calc #(.N(N)) u_calc (
        .a     (dut_a),
        .b     (dut_b),
        .y     (dut_y),
        .match (match),
        .dist  (dist)
    );
`else
    bist_err_calc #(.N(N)) u_calc (
        .a     (dut_a),
        .b     (dut_b),
        .y     (dut_y),
        .match (match)
    );
`endif

    // Next-state and next-register values; everything holds unless a state acts on it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = dut_a;
        b_d     = dut_b;
        busy_d  = busy;
        done_d  = done;
        count_d = correct_count;
`ifdef BIST_ERR_STATS_EN
        sum_d   = err_sum;
        max_d   = err_max;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = FIRST_ST;
                    cnt_d   = '0;
                    a_d     = '0;
                    b_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    count_d = '0;
`ifdef BIST_ERR_STATS_EN
                    sum_d   = '0;
                    max_d   = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + SETTLE_W'(1);
                end
            end
            ST_CHECK: begin
                if (match) begin
                    count_d = correct_count + CW'(1);
                end
`ifdef BIST_ERR_STATS_EN
                sum_d = err_sum + SW'(dist);
                if (dist > err_max) begin
                    max_d = dist;
                end
`endif
                if (last_vec) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // b is the low half, so carry out of b advances a
                    {a_d, b_d} = PW'({dut_a, dut_b}) + PW'(1);
                    state_d    = FIRST_ST;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dut_a         <= '0;
            dut_b         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            correct_count <= '0;
`ifdef BIST_ERR_STATS_EN
            err_sum       <= '0;
            err_max       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dut_a         <= a_d;
            dut_b         <= b_d;
            busy          <= busy_d;
            done          <= done_d;
            correct_count <= count_d;
`ifdef BIST_ERR_STATS_EN
            err_sum       <= sum_d;
            err_max       <= max_d;
`endif
        end
    end

endmodule

// File: tb/tb_approx_mult_bist.sv
// Directed bench for approx_mult_bist with exact, stuck-at-0 and LSB-forced multiplier models.
module tb_approx_mult_bist;
    import approx_mult_bist_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic [1:0] mode;

    logic [3:0] dut_a, dut_b, dut_a2, dut_b2;
    logic [7:0] dut_y, dut_y2, exact1;
    logic       busy, done, busy2, done2;
    logic [8:0] correct_count, correct_count2;
`ifdef BIST_ERR_STATS_EN
    logic [15:0] err_sum, err_sum2;
    logic [7:0]  err_max, err_max2;
`endif

    int checks = 0;
    int errors = 0;
    int cycles;

    always #5 clk = ~clk;

    // Multiplier models under test
    always_comb begin
        exact1 = 8'(dut_a) * 8'(dut_b);
        case (mode)
            2'd0:    dut_y = exact1;
            2'd1:    dut_y = 8'd0;
            default: dut_y = exact1 | 8'd1;
        endcase
    end
    assign dut_y2 = 8'(dut_a2) * 8'(dut_b2);

    approx_mult_bist #(.N(4), .SETTLE(1)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dut_a         (dut_a),
        .dut_b         (dut_b),
        .dut_y         (dut_y),
        .busy          (busy),
        .done          (done),
        .correct_count (correct_count)
`ifdef BIST_ERR_STATS_EN
        ,
        .err_sum       (err_sum),
        .err_max       (err_max)
`endif
    );

    approx_mult_bist #(.N(4), .SETTLE(2)) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .start         (start2),
        .dut_a         (dut_a2),
        .dut_b         (dut_b2),
        .dut_y         (dut_y2),
        .busy          (busy2),
        .done          (done2),
        .correct_count (correct_count2)
`ifdef BIST_ERR_STATS_EN
        ,
        .err_sum       (err_sum2),
        .err_max       (err_max2)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a sweep on u_dut; optionally pulse start or assert rst at a given cycle
    task automatic run_sweep(input int pulse_at, input int rst_at, output int ncyc);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);
        chk("done_clear", 64'(done), 64'd0);
        chk("ops_zero", 64'({dut_a, dut_b}), 64'd0);
        chk("count_clear", 64'(correct_count), 64'd0);
        ncyc = 0;
        while (ncyc < 2000) begin
            @(posedge clk);
            #1 ncyc++;
            if (done) break;
            if (ncyc == 511) chk("busy_hold", 64'(busy), 64'd1);
            start = (ncyc == pulse_at);
            if (ncyc == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_ops", 64'({dut_a, dut_b}), 64'd0);
                chk("rst_count", 64'(correct_count), 64'd0);
                chk("rst_state", 64'(u_dut.state_q), 64'(ST_IDLE));
`ifdef BIST_ERR_STATS_EN
                chk("rst_sum", 64'(err_sum), 64'd0);
                chk("rst_max", 64'(err_max), 64'd0);
`endif
                return;
            end
        end
        start = 1'b0;
        chk("busy_fall", 64'(busy), 64'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        mode   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", 64'(dut_a), 64'd0);
        chk("reset_b", 64'(dut_b), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_count", 64'(correct_count), 64'd0);
`ifdef BIST_ERR_STATS_EN
        chk("reset_sum", 64'(err_sum), 64'd0);
        chk("reset_max", 64'(err_max), 64'd0);
`endif
        rst = 1'b0;

        // Exact multiplier
        run_sweep(-1, -1, cycles);
        chk("exact_cycles", 64'(cycles), 64'd512);
        chk("exact_count", 64'(correct_count), 64'd256);
`ifdef BIST_ERR_STATS_EN
        chk("exact_sum", 64'(err_sum), 64'd0);
        chk("exact_max", 64'(err_max), 64'd0);
`endif
        repeat (5) @(posedge clk);
        #1;
        chk("done_hold", 64'(done), 64'd1);
        chk("count_hold", 64'(correct_count), 64'd256);

        // Stuck-at-0 product, restarted from DONE
        mode = 2'd1;
        run_sweep(-1, -1, cycles);
        chk("zero_cycles", 64'(cycles), 64'd512);
        chk("zero_count", 64'(correct_count), 64'd31);
`ifdef BIST_ERR_STATS_EN
        chk("zero_sum", 64'(err_sum), 64'd14400);
        chk("zero_max", 64'(err_max), 64'd225);
`endif

        // Product with bit 0 forced high
        mode = 2'd2;
        run_sweep(-1, -1, cycles);
        chk("lsb_cycles", 64'(cycles), 64'd512);
        chk("lsb_count", 64'(correct_count), 64'd64);
`ifdef BIST_ERR_STATS_EN
        chk("lsb_sum", 64'(err_sum), 64'd192);
        chk("lsb_max", 64'(err_max), 64'd1);
`endif

        // Mid-sweep start pulse must be ignored
        mode = 2'd0;
        run_sweep(100, -1, cycles);
        chk("pulse_cycles", 64'(cycles), 64'd512);
        chk("pulse_count", 64'(correct_count), 64'd256);
`ifdef BIST_ERR_STATS_EN
        chk("pulse_sum", 64'(err_sum), 64'd0);
`endif

        // Reset aborts a sweep, then a fresh sweep completes normally
        run_sweep(-1, 200, cycles);
        mode = 2'd1;
        run_sweep(-1, -1, cycles);
        chk("post_rst_cycles", 64'(cycles), 64'd512);
        chk("post_rst_count", 64'(correct_count), 64'd31);
`ifdef BIST_ERR_STATS_EN
        chk("post_rst_sum", 64'(err_sum), 64'd14400);
`endif

        // SETTLE=2: each pair held three cycles, b inner loop, a outer loop
        @(negedge clk) start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        chk("s2_order", 64'({dut_a2, dut_b2}), 64'd0);
        cycles = 0;
        while (cycles < 3000) begin
            @(posedge clk);
            #1 cycles++;
            if (cycles <= 53) chk("s2_order", 64'({dut_a2, dut_b2}), 64'(cycles / 3));
            if (done2) break;
        end
        chk("s2_cycles", 64'(cycles), 64'd768);
        chk("s2_count", 64'(correct_count2), 64'd256);
        chk("s2_busy", 64'(busy2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/approx_mult_bist.md
# approx_mult_bist

Sequential built-in self-test engine for the approximate recursive multipliers (M1/M2 4x4 and wider variants). It sweeps every operand pair into a multiplier under test and compares each product against an exact internal reference. It reports the number of exact matches and, optionally, error-distance statistics. It sits beside the DUT multiplier in synthesis or FPGA builds, so accuracy figures can be measured in hardware instead of only in simulation.

## Interface
Parameters:
- `N`, default 4: operand width of the multiplier under test.
- `SETTLE`, default 1: idle cycles between driving operands and sampling `dut_y`. Range 0..15.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: sampled in IDLE or DONE; a high level begins a sweep.
- `dut_a`  out  N: operand A to the DUT (registered).
- `dut_b`  out  N: operand B to the DUT (registered).
- `dut_y`  in  2N: DUT product. It must be stable by the sampling cycle.
- `busy`  out  1: high while a sweep is in progress.
- `done`  out  1: high from sweep completion until the next start or reset.
- `correct_count`  out  2N+1: number of vectors where `dut_y` equals `dut_a*dut_b`.
- `err_sum`  out  4N: sum of |dut_y − a·b| over all vectors. Present only under `BIST_ERR_STATS_EN`.
- `err_max`  out  2N: maximum |dut_y − a·b|. Present only under `BIST_ERR_STATS_EN`.

## Operation
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE or DONE with `start`=1:
  - clear all statistics.
  - set `dut_a`=`dut_b`=0.
  - go to WAIT, or directly to CHECK if SETTLE=0.
- WAIT: count SETTLE cycles, then go to CHECK.
- CHECK: sample `dut_y` and compute exact = `dut_a`·`dut_b` (2N bits, unsigned).
  - Update statistics: `correct_count`+=1 on a match; `err_sum`+=distance; `err_max`=max(`err_max`, distance).
  - If the current vector is the last one (a = b = 2^N−1), go to DONE.
  - Otherwise advance the operands and go to WAIT (or stay in CHECK if SETTLE=0).
- Sweep order: a is the outer loop and b the inner loop.
  - Each step increments b; when b wraps from 2^N−1 to 0, a increments.
  - This is the same order as the simulation sweep, so logs can be compared line for line.
- Arithmetic: all values are unsigned. Distance is the absolute difference, 2N bits. No statistic can overflow at these widths: the maximum `err_sum` is < 2^(4N) and the maximum `correct_count` is 2^(2N).
- `start` in WAIT or CHECK is ignored; a sweep cannot be restarted mid-run.
- `start` in DONE restarts a sweep. Statistics clear on that edge.
- Statistics hold their final values through DONE.

## Timing
- Reset values: `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `correct_count`=0, `err_sum`=0, `err_max`=0. State resets to IDLE.
- Reset during a sweep aborts it. All outputs return to their reset values on the next edge.
- `busy` rises on the edge that samples `start`. It falls on the same edge that `done` rises.
- Per-vector cost is SETTLE+1 cycles. A full sweep takes 2^(2N)·(SETTLE+1) cycles from the `start` edge to `done`.
  - N=4, SETTLE=1: `done` rises 512 cycles after the `start` edge.
- Statistics are updated on the CHECK edge, so the final values are valid in the same cycle `done` first reads high.
- `dut_a`/`dut_b` change only on CHECK edges or on the `start` edge. They hold for at least SETTLE+1 cycles.

## Configuration
- `BIST_ERR_STATS_EN` defined:
  - the `err_sum` and `err_max` ports, registers and the distance adder tree are compiled in.
- Not defined:
  - those ports and registers are absent.
  - only the equality compare and `correct_count` remain.
  - FSM and timing are unchanged.

## Structure
- Package `approx_mult_bist_pkg`: the FSM state enum, the SETTLE counter width, and width helper constants (product 2N, count 2N+1, sum 4N).
- Sub-module `bist_err_calc`: combinational block that takes a, b and y and returns `match` and `dist` (2N bits). It is instantiated once.

## Test plan
- Exact multiplier DUT, N=4, SETTLE=1 → `done` at cycle 512; `correct_count`=256, `err_sum`=0, `err_max`=0.
- DUT tied to `dut_y`=0 → `correct_count`=31 (pairs with a zero operand), `err_sum`=14400, `err_max`=225.
- DUT returns a·b with bit 0 forced to 1 → `correct_count`=64 (odd·odd pairs), `err_sum`=192, `err_max`=1.
- SETTLE=2 with exact DUT → `done` at cycle 768. Check that each operand pair is held 3 cycles and that the order is (0,0),(0,1)…(0,15),(1,0).
- Pulse `start` at cycle 100 of a sweep → ignored and the results are identical to an undisturbed run. Assert `rst` at cycle 200 → next cycle all outputs are 0 and state is IDLE; a new `start` gives full correct results.
- Build without `BIST_ERR_STATS_EN` using the stuck-at-0 DUT → `correct_count`=31, the error ports are absent, and `done` timing is unchanged.
